// File: rtl/pipe_pkg.sv
// Shared pipeline control-bundle layout used by decoder, ID/EX, EX/MEM and forwarding.
// Latency: n/a (constants only). Backpressure: n/a.
package pipe_pkg;
    localparam int CTRL_W_DEFAULT  = 8;
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_ALU_OP_LSB = 3;
    localparam int CTRL_ALU_OP_MSB = 7;

    localparam logic [CTRL_W_DEFAULT-1:0] CTRL_BUBBLE = '0;
endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
// Latency: purely combinational. Backpressure: none.
module load_use_detect #(
    parameter int REGADDR_WIDTH = 4
) (
    input  logic                     id_valid,
    input  logic [REGADDR_WIDTH-1:0] id_rs,
    input  logic [REGADDR_WIDTH-1:0] id_rt,
    input  logic                     id_uses_rs,
    input  logic                     id_uses_rt,
    input  logic                     id_ex_valid,
    input  logic                     id_ex_mem_read,
    input  logic [REGADDR_WIDTH-1:0] id_ex_rd,
    output logic                     load_use
);
    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = id_uses_rs && (id_rs == id_ex_rd);
    assign w_rt_hit = id_uses_rt && (id_rt == id_ex_rd);
    // x0 is hardwired zero, so a load into it never creates a real dependency
    assign load_use = id_valid && id_ex_valid && id_ex_mem_read &&
                      (id_ex_rd != '0) && (w_rs_hit || w_rt_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and deferred branch flush (ID_EX_STATS_EN adds bubble_cnt).
// Latency: 1 cycle ID->EX. Backpressure: ex_stall holds every field; a flush seen during a hold is applied on release.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int REGADDR_WIDTH = 4,
    parameter int CTRL_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [REGADDR_WIDTH-1:0] id_rs,
    input  logic [REGADDR_WIDTH-1:0] id_rt,
    input  logic [REGADDR_WIDTH-1:0] id_rd,
    input  logic                     id_uses_rs,
    input  logic                     id_uses_rt,
    input  logic [DATA_WIDTH-1:0]    id_rs_data,
    input  logic [DATA_WIDTH-1:0]    id_rt_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic [CTRL_WIDTH-1:0]    id_ctrl,
    input  logic                     flush,
    input  logic                     ex_stall,
    output logic                     id_stall,
    output logic                     id_ex_valid,
    output logic [REGADDR_WIDTH-1:0] id_ex_rs,
    output logic [REGADDR_WIDTH-1:0] id_ex_rt,
    output logic [REGADDR_WIDTH-1:0] id_ex_rd,
    output logic [DATA_WIDTH-1:0]    id_ex_rs_data,
    output logic [DATA_WIDTH-1:0]    id_ex_rt_data,
    output logic [DATA_WIDTH-1:0]    id_ex_imm,
    output logic [CTRL_WIDTH-1:0]    id_ex_ctrl,
    output logic                     id_ex_reg_write,
    output logic                     id_ex_mem_read
`ifdef ID_EX_STATS_EN
    ,
    output logic [15:0]              bubble_cnt
`endif
);
    logic                     r_valid;
    logic [REGADDR_WIDTH-1:0] r_rs;
    logic [REGADDR_WIDTH-1:0] r_rt;
    logic [REGADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0]    r_rs_data;
    logic [DATA_WIDTH-1:0]    r_rt_data;
    logic [DATA_WIDTH-1:0]    r_imm;
    logic [CTRL_WIDTH-1:0]    r_ctrl;
    logic                     r_flush_pending;
    logic                     w_load_use;
    logic                     w_squash;

    load_use_detect #(.REGADDR_WIDTH(REGADDR_WIDTH)) u_load_use_detect (
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_ex_valid    (id_ex_valid),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rd       (id_ex_rd),
        .load_use       (w_load_use)
    );

    assign w_squash = flush || r_flush_pending;
    // A squash already removes the consumer, so it must not also freeze the front end
    assign id_stall = rst_n && (ex_stall || (w_load_use && !w_squash));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid         <= 1'b0;
            r_rs            <= '0;
            r_rt            <= '0;
            r_rd            <= '0;
            r_rs_data       <= '0;
            r_rt_data       <= '0;
            r_imm           <= '0;
            r_ctrl          <= '0;
            r_flush_pending <= 1'b0;
        end else if (ex_stall) begin
            if (flush) begin
                r_flush_pending <= 1'b1;
            end
        end else if (w_squash || w_load_use) begin
            r_valid         <= 1'b0;
            r_rs            <= '0;
            r_rt            <= '0;
            r_rd            <= '0;
            r_rs_data       <= '0;
            r_rt_data       <= '0;
            r_imm           <= '0;
            r_ctrl          <= CTRL_WIDTH'(CTRL_BUBBLE);
            r_flush_pending <= 1'b0;
        end else begin
            r_valid   <= id_valid;
            r_rs      <= id_rs;
            r_rt      <= id_rt;
            r_rd      <= id_rd;
            r_rs_data <= id_rs_data;
            r_rt_data <= id_rt_data;
            r_imm     <= id_imm;
            r_ctrl    <= id_valid ? id_ctrl : CTRL_WIDTH'(CTRL_BUBBLE);
        end
    end

`ifdef ID_EX_STATS_EN
    logic [15:0] r_bubble_cnt;

    // Counts only load-use bubbles; flush bubbles are control-flow cost, not hazards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (!ex_stall && !w_squash && w_load_use && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`endif

    assign id_ex_valid     = r_valid;
    assign id_ex_rs        = r_rs;
    assign id_ex_rt        = r_rt;
    assign id_ex_rd        = r_rd;
    assign id_ex_rs_data   = r_rs_data;
    assign id_ex_rt_data   = r_rt_data;
    assign id_ex_imm       = r_imm;
    assign id_ex_ctrl      = r_ctrl;
    assign id_ex_reg_write = r_valid && r_ctrl[CTRL_REG_WRITE];
    assign id_ex_mem_read  = r_valid && r_ctrl[CTRL_MEM_READ];
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hold/flush and reset sequences, then random traffic vs a record model.
// Latency: n/a. Backpressure: random ex_stall; ID inputs held while id_stall is seen.
module tb_id_ex_stage;
    localparam logic [7:0] C_LW  = 8'h03;
    localparam logic [7:0] C_ALU = 8'h09;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_uses_rs, id_uses_rt, flush, ex_stall;
    logic [3:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [7:0]  id_ctrl;
    logic        id_stall, id_ex_valid, id_ex_reg_write, id_ex_mem_read;
    logic [3:0]  id_ex_rs, id_ex_rt, id_ex_rd;
    logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm;
    logic [7:0]  id_ex_ctrl;
`ifdef ID_EX_STATS_EN
    logic [15:0] bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_ctrl(id_ctrl), .flush(flush), .ex_stall(ex_stall), .id_stall(id_stall),
        .id_ex_valid(id_ex_valid), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
        .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
        .id_ex_ctrl(id_ex_ctrl), .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read)
`ifdef ID_EX_STATS_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                          input logic urs, input logic urt, input logic [7:0] ctrl);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt; id_ctrl = ctrl;
        id_rs_data = {28'h1000000, rs}; id_rt_data = {28'h2000000, rt}; id_imm = {28'h3000000, rd};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic v; logic [3:0] rs, rt, rd; logic urs, urt; logic [7:0] ctrl; logic fl;
        logic exp_stall; logic exp_v; logic [3:0] exp_rd, exp_rs; logic [7:0] exp_ctrl;
    } vec_t;

    function automatic vec_t mk(logic v, logic [3:0] rs, logic [3:0] rt, logic [3:0] rd, logic urs, logic urt,
                                logic [7:0] ctrl, logic fl, logic es, logic ev, logic [3:0] erd,
                                logic [3:0] ers, logic [7:0] ec);
        vec_t t;
        t.v = v; t.rs = rs; t.rt = rt; t.rd = rd; t.urs = urs; t.urt = urt; t.ctrl = ctrl; t.fl = fl;
        t.exp_stall = es; t.exp_v = ev; t.exp_rd = erd; t.exp_rs = ers; t.exp_ctrl = ec;
        return t;
    endfunction

    typedef struct {
        logic v; logic [3:0] rs, rt, rd; logic [31:0] a, b, imm; logic [7:0] ctrl;
    } ex_rec_t;

    ex_rec_t m_ex;
    logic    m_pend;
    int      m_cnt;

    task automatic check_ex(input string tag);
        chk({tag, ".valid"}, 64'(id_ex_valid), 64'(m_ex.v));
        chk({tag, ".rs"}, 64'(id_ex_rs), 64'(m_ex.rs));
        chk({tag, ".rt"}, 64'(id_ex_rt), 64'(m_ex.rt));
        chk({tag, ".rd"}, 64'(id_ex_rd), 64'(m_ex.rd));
        chk({tag, ".a"}, 64'(id_ex_rs_data), 64'(m_ex.a));
        chk({tag, ".b"}, 64'(id_ex_rt_data), 64'(m_ex.b));
        chk({tag, ".imm"}, 64'(id_ex_imm), 64'(m_ex.imm));
        chk({tag, ".ctrl"}, 64'(id_ex_ctrl), 64'(m_ex.ctrl));
        chk({tag, ".reg_write"}, 64'(id_ex_reg_write), 64'(m_ex.v & m_ex.ctrl[0]));
        chk({tag, ".mem_read"}, 64'(id_ex_mem_read), 64'(m_ex.v & m_ex.ctrl[1]));
`ifdef ID_EX_STATS_EN
        chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(m_cnt));
`endif
    endtask

    vec_t tbl[19];

    initial begin
        logic lu, exp_stall, hold;
        ex_rec_t bub;
        bub = '{v: 1'b0, rs: 4'd0, rt: 4'd0, rd: 4'd0, a: 32'd0, b: 32'd0, imm: 32'd0, ctrl: 8'd0};

        //          v  rs rt rd urs urt ctrl  fl  stall v  rd rs ctrl
        tbl[0]  = mk(1, 1, 0, 3, 1, 0, C_LW,  0,  0,    1, 3, 1, C_LW);
        tbl[1]  = mk(1, 3, 4, 5, 1, 1, C_ALU, 0,  1,    0, 0, 0, 8'h00);
        tbl[2]  = mk(1, 3, 4, 5, 1, 1, C_ALU, 0,  0,    1, 5, 3, C_ALU);
        tbl[3]  = mk(1, 2, 0, 0, 1, 0, C_LW,  0,  0,    1, 0, 2, C_LW);
        tbl[4]  = mk(1, 0, 4, 5, 1, 1, C_ALU, 0,  0,    1, 5, 0, C_ALU);
        tbl[5]  = mk(1, 1, 0, 3, 1, 0, C_LW,  0,  0,    1, 3, 1, C_LW);
        tbl[6]  = mk(1, 7, 3, 5, 1, 0, C_ALU, 0,  0,    1, 5, 7, C_ALU);
        tbl[7]  = mk(1, 1, 0, 6, 1, 0, C_LW,  0,  0,    1, 6, 1, C_LW);
        tbl[8]  = mk(1, 2, 6, 7, 1, 1, C_ALU, 0,  1,    0, 0, 0, 8'h00);
        tbl[9]  = mk(1, 2, 6, 7, 1, 1, C_ALU, 0,  0,    1, 7, 2, C_ALU);
        tbl[10] = mk(1, 1, 0, 3, 1, 0, C_LW,  0,  0,    1, 3, 1, C_LW);
        tbl[11] = mk(1, 3, 4, 5, 1, 1, C_ALU, 1,  0,    0, 0, 0, 8'h00);
        tbl[12] = mk(0, 3, 3, 3, 1, 1, C_LW,  0,  0,    0, 3, 3, 8'h00);
        tbl[13] = mk(1, 1, 0, 3, 1, 0, C_LW,  0,  0,    1, 3, 1, C_LW);
        tbl[14] = mk(1, 3, 4, 5, 1, 1, C_ALU, 0,  1,    0, 0, 0, 8'h00);
        tbl[15] = mk(1, 3, 4, 5, 1, 1, C_ALU, 0,  0,    1, 5, 3, C_ALU);
        tbl[16] = mk(1, 1, 0, 8, 1, 0, C_LW,  0,  0,    1, 8, 1, C_LW);
        tbl[17] = mk(1, 8, 4, 5, 1, 1, C_ALU, 0,  1,    0, 0, 0, 8'h00);
        tbl[18] = mk(1, 8, 4, 5, 1, 1, C_ALU, 0,  0,    1, 5, 8, C_ALU);

        // reset state, with ex_stall high to show id_stall is masked in reset
        rst_n = 1'b0; flush = 1'b0; ex_stall = 1'b1;
        set_id(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 8'h00);
        #1;
        chk("reset.id_stall", 64'(id_stall), 64'd0);
        chk("reset.valid", 64'(id_ex_valid), 64'd0);
        chk("reset.ctrl", 64'(id_ex_ctrl), 64'd0);
        ex_stall = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        step();

        foreach (tbl[i]) begin
            set_id(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].urs, tbl[i].urt, tbl[i].ctrl);
            flush = tbl[i].fl;
            @(negedge clk);
            chk($sformatf("tbl%0d.id_stall", i), 64'(id_stall), 64'(tbl[i].exp_stall));
            step();
            chk($sformatf("tbl%0d.valid", i), 64'(id_ex_valid), 64'(tbl[i].exp_v));
            chk($sformatf("tbl%0d.rd", i), 64'(id_ex_rd), 64'(tbl[i].exp_rd));
            chk($sformatf("tbl%0d.rs", i), 64'(id_ex_rs), 64'(tbl[i].exp_rs));
            chk($sformatf("tbl%0d.ctrl", i), 64'(id_ex_ctrl), 64'(tbl[i].exp_ctrl));
        end
        flush = 1'b0;
`ifdef ID_EX_STATS_EN
        chk("tbl.bubble_cnt", 64'(bubble_cnt), 64'd4);
`endif

        // three-cycle hold with flush in the middle cycle
        set_id(1'b1, 4'd9, 4'd2, 4'd10, 1'b1, 1'b1, C_ALU);
        ex_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            flush = (c == 1);
            @(negedge clk);
            chk($sformatf("hold%0d.id_stall", c), 64'(id_stall), 64'd1);
            step();
            chk($sformatf("hold%0d.valid", c), 64'(id_ex_valid), 64'd1);
            chk($sformatf("hold%0d.rd", c), 64'(id_ex_rd), 64'd5);
            chk($sformatf("hold%0d.rs", c), 64'(id_ex_rs), 64'd8);
        end
        ex_stall = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("release.id_stall", 64'(id_stall), 64'd0);
        step();
        chk("release.bubble_valid", 64'(id_ex_valid), 64'd0);
        chk("release.bubble_ctrl", 64'(id_ex_ctrl), 64'd0);
        step();
        chk("release.capture_valid", 64'(id_ex_valid), 64'd1);
        chk("release.capture_rd", 64'(id_ex_rd), 64'd10);

        // async reset while a deferred flush is pending
        set_id(1'b1, 4'd1, 4'd0, 4'd3, 1'b1, 1'b0, C_LW);
        step();
        ex_stall = 1'b1; flush = 1'b1;
        step();
        chk("rstmid.held_rd", 64'(id_ex_rd), 64'd3);
        flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.valid", 64'(id_ex_valid), 64'd0);
        chk("rstmid.rd", 64'(id_ex_rd), 64'd0);
        chk("rstmid.ctrl", 64'(id_ex_ctrl), 64'd0);
        chk("rstmid.id_stall", 64'(id_stall), 64'd0);
        ex_stall = 1'b0;
        set_id(1'b1, 4'd3, 4'd3, 4'd4, 1'b1, 1'b0, C_ALU);
        @(negedge clk); rst_n = 1'b1;
        step();
        chk("rstmid.after_valid", 64'(id_ex_valid), 64'd1);
        chk("rstmid.after_rd", 64'(id_ex_rd), 64'd4);
        chk("rstmid.after_rs", 64'(id_ex_rs), 64'd3);

        // random traffic against the instruction-record model
        rst_n = 1'b0; #1;
        @(negedge clk); rst_n = 1'b1;
        m_ex = bub; m_pend = 1'b0; m_cnt = 0; hold = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                set_id(($urandom_range(0, 9) < 8), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                       4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 8'($urandom));
                id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
            end
            flush    = ($urandom_range(0, 9) == 0);
            ex_stall = ($urandom_range(0, 4) == 0);
            lu = id_valid && m_ex.v && m_ex.ctrl[1] && (m_ex.rd != 0) &&
                 ((id_uses_rs && id_rs == m_ex.rd) || (id_uses_rt && id_rt == m_ex.rd));
            exp_stall = ex_stall || (lu && !flush && !m_pend);
            @(negedge clk);
            chk($sformatf("rnd%0d.id_stall", n), 64'(id_stall), 64'(exp_stall));
            if (ex_stall) begin
                m_pend = m_pend | flush;
            end else if (flush || m_pend) begin
                m_ex = bub; m_pend = 1'b0;
            end else if (lu) begin
                m_ex = bub;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_ex = '{v: id_valid, rs: id_rs, rt: id_rt, rd: id_rd, a: id_rs_data, b: id_rt_data,
                         imm: id_imm, ctrl: (id_valid ? id_ctrl : 8'h00)};
            end
            hold = exp_stall;
            step();
            check_ex($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
